// File: rtl/rv_alu_pkg.sv
// Shared ALU op codes, branch/jump helpers
// and EX controller state encoding.
package rv_alu_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [3:0] ALU_BEQ  = 4'b1001;
  localparam logic [3:0] ALU_BNE  = 4'b1010;
  localparam logic [3:0] ALU_BLT  = 4'b1011;
  localparam logic [3:0] ALU_BGE  = 4'b1100;
  localparam logic [3:0] ALU_JAL  = 4'b1101;
  localparam logic [3:0] ALU_JALR = 4'b1110;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } ex_state_t;

  function automatic logic is_branch(
    input logic [3:0] sel
  );
    return (sel >= ALU_BEQ) &&
           (sel <= ALU_BGE);
  endfunction

  function automatic logic is_jump(
    input logic [3:0] sel
  );
    return (sel == ALU_JAL) ||
           (sel == ALU_JALR);
  endfunction

endpackage

// File: rtl/ex_target_gen.sv
// Target/link adders for the EX stage.
// Ports: i_pc, i_rs1, i_imm in; o_pc_imm, o_jalr_tgt, o_pc4 out.
module ex_target_gen #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_imm,
  output logic [XLEN-1:0] o_pc_imm,
  output logic [XLEN-1:0] o_jalr_tgt,
  output logic [XLEN-1:0] o_pc4
);

  logic [XLEN-1:0] w_rs1_imm;

  assign o_pc_imm   = i_pc + i_imm;
  assign w_rs1_imm  = i_rs1 + i_imm;
  // JALR clears bit 0 of the target
  assign o_jalr_tgt = {w_rs1_imm[XLEN-1:1], 1'b0};
  assign o_pc4      = i_pc + XLEN'(4);

endmodule

// File: rtl/ex_alu_ctrl.sv
// EX-stage controller: ALU operand select, EX/MEM slot,
// branch redirect and wrong-path squash.
// Ports: in_* ID/EX handshake, alu_* ALU, out_* EX/MEM,
// redirect_* one-cycle PC redirect.
module ex_alu_ctrl
  import rv_alu_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [3:0]      in_alu_sel,
  input  logic            in_use_imm,
  input  logic            in_use_pc,
  input  logic [4:0]      in_rd,
  input  logic            in_wb_en,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] alu_c,
  input  logic            alu_branch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  ex_state_t       r_state;
  ex_state_t       w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_result;
  logic [4:0]      r_out_rd;
  logic            r_out_wb_en;
  logic            r_redir_valid;
  logic [XLEN-1:0] r_redir_pc;

  logic            w_is_br;
  logic            w_is_jmp;
  logic            w_fire;
  logic            w_run_fire;
  logic [XLEN-1:0] w_pc_imm;
  logic [XLEN-1:0] w_jalr_tgt;
  logic [XLEN-1:0] w_pc4;

  ex_target_gen #(
    .XLEN (XLEN)
  ) u_tgt (
    .i_pc       (in_pc),
    .i_rs1      (in_rs1),
    .i_imm      (in_imm),
    .o_pc_imm   (w_pc_imm),
    .o_jalr_tgt (w_jalr_tgt),
    .o_pc4      (w_pc4)
  );

  assign w_is_br  = is_branch(in_alu_sel);
  assign w_is_jmp = is_jump(in_alu_sel);

  // Compares always use rs1/rs2 whatever
  // the decoder put on the use flags.
  always_comb begin
    alu_a = in_rs1;
    alu_b = in_rs2;
    unique case (1'b1)
      w_is_br: begin
        alu_a = in_rs1;
        alu_b = in_rs2;
      end
      default: begin
        alu_a = in_use_pc  ? in_pc  : in_rs1;
        alu_b = in_use_imm ? in_imm : in_rs2;
      end
    endcase
  end

  assign alu_sel = in_alu_sel;

  // Wrong-path fetches are dropped, so a
  // stalled slot never blocks the flush.
  assign in_ready = (r_state == ST_FLUSH) ||
                    !r_out_valid || out_ready;

  assign w_fire     = in_valid && in_ready;
  assign w_run_fire = w_fire && (r_state == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_RUN: begin
        if (w_fire && alu_branch) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = CW'(FLUSH_CYCLES);
        end
      end
      ST_FLUSH: begin
        if (w_fire) begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == CW'(1))
            w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_out_rd      <= '0;
      r_out_wb_en   <= 1'b0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= '0;
    end else begin
      r_redir_valid <= 1'b0;
      if (w_run_fire) begin
        r_out_valid  <= 1'b1;
        r_out_rd     <= in_rd;
        r_out_result <= w_is_jmp ? w_pc4 : alu_c;
        r_out_wb_en  <= in_wb_en && !w_is_br;
        if (alu_branch) begin
          r_redir_valid <= 1'b1;
          r_redir_pc    <=
            (in_alu_sel == ALU_JALR) ?
            w_jalr_tgt : w_pc_imm;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign out_result     = r_out_result;
  assign out_rd         = r_out_rd;
  assign out_wb_en      = r_out_wb_en;
  assign redirect_valid = r_redir_valid;
  assign redirect_pc    = r_redir_pc;

endmodule
